// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: request/response bundle between the control unit and mem_ctrl.
// Ports: master = control unit side (drives requests), slave = mem_ctrl side.
interface mem_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
);
    logic                  Read;
    logic                  Write;
    logic [ADDR_WIDTH-1:0] MAR_addr;
    logic [DATA_WIDTH-1:0] MDR_data;
    logic [DATA_WIDTH-1:0] Mdatain;
    logic                  mdr_read;
    logic                  mdr_load;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        output Read, Write, MAR_addr, MDR_data,
        input  Mdatain, mdr_read, mdr_load, busy, done, err
    );

    modport slave (
        input  Read, Write, MAR_addr, MDR_data,
        output Mdatain, mdr_read, mdr_load, busy, done, err
    );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: word RAM with wait states feeding the MDR (Mdatain/read/MDRin).
// Ports: clock, clear (async, active-high), bus (mem_ctrl_if.slave).
module mem_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 9,
    parameter int WAIT_STATES = 1
) (
    input  logic       clock,
    input  logic       clear,
    mem_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int DEPTH = 1 << ADDR_WIDTH;

    state_t                state;
    logic [3:0]            cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  op_q;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  mdr_read;
    logic                  mdr_load;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic                  req_one;
    logic                  req_both;
    logic                  wr_en;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign req_one  = bus.Read ^ bus.Write;
    assign req_both = bus.Read & bus.Write;

    // The write fires on the final access edge; a clear drops state to
    // IDLE at once, so an aborted write never reaches the array.
    assign wr_en = (state == ACCESS) && (cnt == 4'd0) && !op_q;

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[addr_q] <= data_q;
        end
    end

    // DONE samples requests like IDLE so a held request is accepted on the
    // edge that leaves DONE, giving one access per WAIT_STATES+2 cycles.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            addr_q   <= '0;
            data_q   <= '0;
            op_q     <= 1'b0;
            rdata    <= '0;
            mdr_read <= 1'b0;
            mdr_load <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done     <= 1'b0;
            mdr_load <= 1'b0;
            err      <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    mdr_read <= 1'b0;
                    if (req_one) begin
                        addr_q   <= bus.MAR_addr;
                        data_q   <= bus.MDR_data;
                        op_q     <= bus.Read;
                        cnt      <= 4'(WAIT_STATES);
                        state    <= ACCESS;
                        busy     <= 1'b1;
                        mdr_read <= bus.Read;
                    end else if (req_both) begin
                        err <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (op_q) begin
                            rdata <= mem[addr_q];
                        end
                        state    <= DONE;
                        done     <= 1'b1;
                        mdr_load <= op_q;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    mdr_read <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Mdatain  = rdata;
    assign bus.mdr_read = mdr_read;
    assign bus.mdr_load = mdr_load;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.err      = err;
endmodule
